// File: rtl/ttl_serial_subtractor.sv
// Multi-cycle A - B - Borrow_in built from one SLICE-bit adder slice, LS slice first.
// Define SUB_FLAGS_EN to add the registered Zero and Overflow result flags.
module ttl_serial_subtractor #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Borrow_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Diff,
   output logic             Borrow_out
`ifdef SUB_FLAGS_EN
   ,
   output logic             Zero,
   output logic             Overflow
`endif
);

   localparam int N    = WIDTH / SLICE;
   localparam int IDXW = (N > 1) ? $clog2(N) : 1;

   if ((WIDTH % SLICE) != 0) begin : g_bad_slice
      $error("ttl_serial_subtractor: WIDTH must be a multiple of SLICE");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state_reg, state_next;
   logic [WIDTH-1:0]  a_sh_reg, b_sh_reg, res_sh_reg;
   logic [WIDTH-1:0]  res_next;
   logic [IDXW-1:0]   idx_reg;
   logic              carry_reg;
   logic              a_msb_reg, b_msb_reg;
   logic [SLICE:0]    sum;
   logic              accept;
   logic              last;

   assign accept = start && (state_reg != RUN);
   assign last   = (idx_reg == IDXW'(N - 1));
   assign busy   = (state_reg == RUN);
   assign done   = (state_reg == DONE);

   // One adder slice: A + ~B + carry, where carry is the inverted borrow.
   assign sum = {1'b0, a_sh_reg[SLICE-1:0]} + {1'b0, ~b_sh_reg[SLICE-1:0]}
              + {{SLICE{1'b0}}, carry_reg};

   // Slice results enter at the top so slice 0 ends up in the LS position.
   if (SLICE == WIDTH) begin : g_single
      assign res_next = sum[SLICE-1:0];
   end else begin : g_multi
      assign res_next = {sum[SLICE-1:0], res_sh_reg[WIDTH-1:SLICE]};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last)  state_next = DONE;
         DONE:    state_next = start ? RUN : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_sh_reg   <= '0;
         b_sh_reg   <= '0;
         res_sh_reg <= '0;
         idx_reg    <= '0;
         carry_reg  <= 1'b0;
         a_msb_reg  <= 1'b0;
         b_msb_reg  <= 1'b0;
         Diff       <= '0;
         Borrow_out <= 1'b0;
`ifdef SUB_FLAGS_EN
         Zero       <= 1'b0;
         Overflow   <= 1'b0;
`endif
      end else if (accept) begin
         a_sh_reg   <= A;
         b_sh_reg   <= B;
         res_sh_reg <= '0;
         idx_reg    <= '0;
         carry_reg  <= ~Borrow_in;
         a_msb_reg  <= A[WIDTH-1];
         b_msb_reg  <= B[WIDTH-1];
      end else if (state_reg == RUN) begin
         a_sh_reg   <= a_sh_reg >> SLICE;
         b_sh_reg   <= b_sh_reg >> SLICE;
         res_sh_reg <= res_next;
         carry_reg  <= sum[SLICE];
         idx_reg    <= idx_reg + IDXW'(1);
         // Outputs only move at completion so partial sums never leak out.
         if (last) begin
            Diff       <= res_next;
            Borrow_out <= ~sum[SLICE];
`ifdef SUB_FLAGS_EN
            Zero       <= (res_next == '0);
            Overflow   <= (a_msb_reg != b_msb_reg) && (res_next[WIDTH-1] != a_msb_reg);
`endif
         end
      end
   end

endmodule
